// File: rtl/cordic_pkg.sv
// Shared definitions for the cordic_top sharing arbiter: FSM encoding and default sizing.
package cordic_pkg;
  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;
endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first asserted request at or above ptr, wrapping to 0.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic w_found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    // k is the search distance from ptr; the first hit wins
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!w_found && req[j] && (j == ((int'(ptr) + k) % N))) begin
          w_found  = 1'b1;
          grant[j] = 1'b1;
          idx      = IW'(j);
        end
      end
    end
  end
endmodule

// File: rtl/cordic_arbiter.sv
// Shares one cordic_top among N_REQ requesters: round-robin accept, reset+start the
// core, wait for done (with timeout), then hold the result until the consumer takes it.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*32-1:0]   req_angle,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  cord_rst,
  output logic                  cord_valid_in,
  output logic [31:0]           cord_angle,
  input  logic                  cord_done,
  input  logic [31:0]           cord_sin,
  input  logic [31:0]           cord_cos,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_sin,
  output logic [31:0]           resp_cos,
  output logic                  resp_err
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t             r_state, w_nstate;
  logic [ID_W-1:0]    r_ptr, r_id;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_angle, r_sin, r_cos;
  logic               r_err;

  logic [N_REQ-1:0]   w_grant;
  logic [ID_W-1:0]    w_idx;
  logic [31:0]        w_ang;
  logic               w_any, w_timeout;

  rr_select #(.N(N_REQ), .IW(ID_W)) u_rr (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx)
  );

  assign w_any     = |req_valid;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_ang = '0;
    for (int i = 0; i < N_REQ; i++)
      if (w_idx == ID_W'(i)) w_ang = req_angle[i*32 +: 32];
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_nstate = ST_CLR;
      ST_CLR:   w_nstate = ST_ISSUE;
      ST_ISSUE: w_nstate = ST_WAIT;
      ST_WAIT:  if (cord_done || w_timeout) w_nstate = ST_RESP;
      ST_RESP:  if (resp_ready) w_nstate = ST_IDLE;
      default:  w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_cnt   <= '0;
      r_angle <= '0;
      r_sin   <= '0;
      r_cos   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_angle <= w_ang;
          r_id    <= w_idx;
          r_ptr   <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + ID_W'(1);
        end
        ST_CLR: r_cnt <= '0;
        ST_WAIT: begin
          // done takes priority over an expiring timeout in the same cycle
          if (cord_done) begin
            r_sin <= cord_sin;
            r_cos <= cord_cos;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_sin <= '0;
            r_cos <= '0;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = (r_state == ST_IDLE && !rst) ? w_grant : '0;
  assign cord_rst      = rst || (r_state == ST_CLR);
  assign cord_valid_in = !rst && (r_state == ST_ISSUE);
  assign cord_angle    = r_angle;
  assign resp_valid    = !rst && (r_state == ST_RESP);
  assign resp_id       = r_id;
  assign resp_sin      = r_sin;
  assign resp_cos      = r_cos;
  assign resp_err      = r_err;
endmodule
